// File: rtl/fetch_pkg.sv
// Shared fetch-path constants and the instruction-queue entry layout.
package fetch_pkg;

    localparam int              XLEN             = 32;
    localparam int              ILEN             = 32;
    localparam logic [ILEN-1:0] NOP_INSN         = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [ILEN-1:0] ir;
        logic [XLEN-1:0] pc;
    } fq_entry_t;

endpackage

// File: rtl/m_fetch_queue_if.sv
// Bundle of the redirect, instruction-memory and ID-stage signals around the fetch queue.
interface m_fetch_queue_if;
    import fetch_pkg::*;

    logic            w_redir;
    logic [XLEN-1:0] w_redir_pc;

    logic            w_imem_req;
    logic [XLEN-1:0] w_imem_adr;
    logic            w_imem_gnt;
    logic            w_imem_rvalid;
    logic [ILEN-1:0] w_imem_rdata;

    logic            w_id_valid;
    logic [ILEN-1:0] w_id_ir;
    logic [XLEN-1:0] w_id_pc;
    logic [XLEN-1:0] w_id_npc;
    logic            w_id_ready;

    // master is the fetch queue; slave is the surrounding core/memory
    modport master (
        input  w_redir, w_redir_pc, w_imem_gnt, w_imem_rvalid, w_imem_rdata, w_id_ready,
        output w_imem_req, w_imem_adr, w_id_valid, w_id_ir, w_id_pc, w_id_npc
    );

    modport slave (
        output w_redir, w_redir_pc, w_imem_gnt, w_imem_rvalid, w_imem_rdata, w_id_ready,
        input  w_imem_req, w_imem_adr, w_id_valid, w_id_ir, w_id_pc, w_id_npc
    );

endinterface

// File: rtl/m_sync_fifo.sv
// Synchronous circular FIFO; pointers carry one extra bit to tell full from empty.
module m_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic                    i_flush,
    input  logic [WIDTH-1:0]        i_wdata,
    output logic [WIDTH-1:0]        o_rdata,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // NOTE: the storage array has no reset; occupancy comes only from the pointers.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/m_fetch_queue.sv
// Fetch front end: PC generator, credit-limited imem request port and an in-order
// instruction queue feeding ID; a redirect flushes the queue and drops in-flight fetches.
module m_fetch_queue
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input logic             w_clk,
    input logic             w_rst_n,
    m_fetch_queue_if.master bus
);
    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);
    localparam logic [CW:0]     CREDITS = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0] r_fpc;
    logic [XLEN-1:0] r_rpc;
    logic [CW-1:0]   r_out;
    logic [CW-1:0]   r_drop;
    logic [CW-1:0]   w_cnt;
    logic            w_rsp;
    logic            w_req;
    logic            w_fire;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic            w_valid;
    fq_entry_t       w_wr_ent;
    fq_entry_t       w_head;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_rsp    = bus.w_imem_rvalid && (r_out != '0);
    // Each request reserves a queue slot, so the queue can never overflow.
    assign w_req    = w_rst_n && !bus.w_redir &&
                      (({1'b0, r_out} + {1'b0, w_cnt}) < CREDITS);
    assign w_fire   = w_req && bus.w_imem_gnt;
    assign w_push   = w_rsp && (r_drop == '0) && !bus.w_redir;
    assign w_valid  = !w_empty;
    assign w_pop    = w_valid && bus.w_id_ready && !bus.w_redir;
    assign w_wr_ent = '{ir: bus.w_imem_rdata, pc: r_rpc};

    m_sync_fifo #(
        .WIDTH ($bits(fq_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (w_clk),
        .i_rst_n (w_rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.w_redir),
        .i_wdata (w_wr_ent),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_cnt)
    );

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_fpc  <= RESET_PC;
            r_rpc  <= RESET_PC;
            r_drop <= '0;
        end else if (bus.w_redir) begin
            r_fpc  <= bus.w_redir_pc;
            r_rpc  <= bus.w_redir_pc;
            // everything still outstanding after this cycle's response belongs to the old path
            r_drop <= r_out - (w_rsp ? CNT_ONE : '0);
        end else begin
            if (w_fire) r_fpc <= r_fpc + PC_STEP;
            if (w_push) r_rpc <= r_rpc + PC_STEP;
            if (w_rsp && (r_drop != '0)) r_drop <= r_drop - CNT_ONE;
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_out <= '0;
        end else begin
            case ({w_fire, w_rsp})
                2'b10:   r_out <= r_out + CNT_ONE;
                2'b01:   r_out <= r_out - CNT_ONE;
                default: r_out <= r_out;
            endcase
        end
    end

    assign bus.w_imem_req = w_req;
    assign bus.w_imem_adr = r_fpc;
    assign bus.w_id_valid = w_valid;
    assign bus.w_id_ir    = w_valid ? w_head.ir : NOP_INSN;
    assign bus.w_id_pc    = w_valid ? w_head.pc : '0;
    assign bus.w_id_npc   = bus.w_id_pc + PC_STEP;

    a_rsp_credit: assert property (@(posedge w_clk) disable iff (!w_rst_n)
        bus.w_imem_rvalid |-> (r_out != '0));

    a_no_overflow: assert property (@(posedge w_clk) disable iff (!w_rst_n)
        w_push |-> (!w_full || w_pop));

endmodule

// File: tb/tb_m_fetch_queue.sv
// Self-checking bench for m_fetch_queue: directed vector table, corner sequences
// and a randomized run against a queue-based reference model.
module tb_m_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;

    m_fetch_queue_if bus ();

    m_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .w_clk   (clk),
        .w_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct { logic [31:0] data; int due; } rsp_t;
    typedef struct { logic [31:0] adr;  bit keep; } os_t;
    typedef struct { logic [31:0] ir;   logic [31:0] pc; } ent_t;
    typedef struct {
        bit          gnt;
        bit          ready;
        bit          exp_req;
        logic [31:0] exp_adr;
        bit          exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_ir;
    } vec_t;

    rsp_t        pend[$];
    os_t         m_os[$];
    ent_t        m_q[$];
    logic [31:0] m_fpc;

    int n_pass;
    int n_total;
    int cyc;

    logic        s_req, s_valid;
    logic [31:0] s_adr, s_ir, s_pc, s_npc;

    vec_t vt[15];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a >> 2) * 32'h100 + 32'h13;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock cycle: drive inputs just after negedge, sample, compare with model, advance.
    task automatic drive(input bit gnt, input bit ready, input bit redir,
                         input logic [31:0] rpc, input int lat);
        bit          rv;
        bit          e_req, e_valid, do_pop;
        logic [31:0] e_ir, e_pc;
        os_t         o;
        rv = (pend.size() > 0) && (pend[0].due <= cyc);
        bus.w_imem_gnt    = gnt;
        bus.w_id_ready    = ready;
        bus.w_redir       = redir;
        bus.w_redir_pc    = rpc;
        bus.w_imem_rvalid = rv;
        bus.w_imem_rdata  = rv ? pend[0].data : 32'hDEAD_BEEF;
        #1;
        s_req   = bus.w_imem_req;
        s_adr   = bus.w_imem_adr;
        s_valid = bus.w_id_valid;
        s_ir    = bus.w_id_ir;
        s_pc    = bus.w_id_pc;
        s_npc   = bus.w_id_npc;

        e_req   = !redir && ((m_os.size() + m_q.size()) < DEPTH);
        e_valid = (m_q.size() != 0);
        e_ir    = e_valid ? m_q[0].ir : NOP_INSN;
        e_pc    = e_valid ? m_q[0].pc : 32'h0;
        check("req",   s_req,   e_req);
        check("adr",   s_adr,   m_fpc);
        check("valid", s_valid, e_valid);
        check("ir",    s_ir,    e_ir);
        check("pc",    s_pc,    e_pc);
        check("npc",   s_npc,   e_pc + 32'd4);

        // memory: responds in order to what the DUT actually requested
        if (rv) void'(pend.pop_front());
        if (s_req && gnt) pend.push_back('{data: word(s_adr), due: cyc + lat});

        // reference model
        if (redir) begin
            if (rv && m_os.size() > 0) void'(m_os.pop_front());
            foreach (m_os[i]) m_os[i].keep = 1'b0;
            m_q.delete();
            m_fpc = rpc;
        end else begin
            do_pop = e_valid && ready;
            if (do_pop) void'(m_q.pop_front());
            if (rv && m_os.size() > 0) begin
                o = m_os.pop_front();
                if (o.keep) m_q.push_back('{ir: bus.w_imem_rdata, pc: o.adr});
            end
            if (e_req && gnt) begin
                m_os.push_back('{adr: m_fpc, keep: 1'b1});
                m_fpc = m_fpc + 32'd4;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        bus.w_redir       = 1'b0;
        bus.w_redir_pc    = 32'h0;
        bus.w_imem_gnt    = 1'b0;
        bus.w_imem_rvalid = 1'b0;
        bus.w_imem_rdata  = 32'h0;
        bus.w_id_ready    = 1'b0;
        pend.delete();
        m_os.delete();
        m_q.delete();
        m_fpc = 32'h0;
        #1;
        check("rst_req",   bus.w_imem_req, 1'b0);
        check("rst_adr",   bus.w_imem_adr, 32'h0);
        check("rst_valid", bus.w_id_valid, 1'b0);
        check("rst_ir",    bus.w_id_ir,    NOP_INSN);
        check("rst_pc",    bus.w_id_pc,    32'h0);
        check("rst_npc",   bus.w_id_npc,   32'h4);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        bit          g, r, rd, found;
        logic [31:0] rp;
        n_pass  = 0;
        n_total = 0;
        cyc     = 0;
        rst_n   = 1'b1;

        // streaming then backpressure, zero-wait memory
        vt[0]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 32'h013};
        vt[1]  = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00, 32'h013};
        vt[2]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00, 32'h013};
        vt[3]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04, 32'h113};
        vt[4]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08, 32'h213};
        vt[5]  = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C, 32'h313};
        vt[6]  = '{1'b1, 1'b0, 1'b1, 32'h18, 1'b1, 32'h10, 32'h413};
        vt[7]  = '{1'b1, 1'b0, 1'b1, 32'h1C, 1'b1, 32'h10, 32'h413};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 32'h20, 1'b1, 32'h10, 32'h413};
        vt[9]  = '{1'b1, 1'b0, 1'b0, 32'h20, 1'b1, 32'h10, 32'h413};
        vt[10] = '{1'b1, 1'b1, 1'b0, 32'h20, 1'b1, 32'h10, 32'h413};
        vt[11] = '{1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h14, 32'h513};
        vt[12] = '{1'b1, 1'b1, 1'b1, 32'h24, 1'b1, 32'h18, 32'h613};
        vt[13] = '{1'b1, 1'b1, 1'b1, 32'h28, 1'b1, 32'h1C, 32'h713};
        vt[14] = '{1'b1, 1'b1, 1'b1, 32'h2C, 1'b1, 32'h20, 32'h813};

        apply_reset();
        for (int i = 0; i < 15; i++) begin
            drive(vt[i].gnt, vt[i].ready, 1'b0, 32'h0, 1);
            check($sformatf("vec%0d_req", i),   s_req,   vt[i].exp_req);
            check($sformatf("vec%0d_adr", i),   s_adr,   vt[i].exp_adr);
            check($sformatf("vec%0d_valid", i), s_valid, vt[i].exp_valid);
            check($sformatf("vec%0d_pc", i),    s_pc,    vt[i].exp_pc);
            check($sformatf("vec%0d_ir", i),    s_ir,    vt[i].exp_ir);
        end

        // grant stall: address holds at 0x8 until granted
        apply_reset();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0, 1);
            check("stall_adr", s_adr, 32'h8);
            check("stall_req", s_req, 1'b1);
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1);
        check("stall_gnt_adr", s_adr, 32'h8);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1);
        check("stall_next_adr", s_adr, 32'hC);

        // redirect with two fetches in flight, memory latency 3
        apply_reset();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 3);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 3);
        drive(1'b1, 1'b1, 1'b1, 32'h100, 3);
        check("redir_req_suppressed", s_req, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 3);
        check("redir_new_adr", s_adr, 32'h100);
        check("redir_new_req", s_req, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0, 3);
            if (s_valid) begin
                found = 1'b1;
                check("redir_first_pc",  s_pc,  32'h100);
                check("redir_first_npc", s_npc, 32'h104);
                check("redir_first_ir",  s_ir,  word(32'h100));
            end
        end
        if (!found) check("redir_first_valid_timeout", 32'h0, 32'h1);

        // coincident redirect + response + consume, target near the top of the address space
        apply_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 32'h0, 1);
        drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1);
        check("coinc_head_valid", s_valid, 1'b1);
        check("coinc_req",        s_req,   1'b0);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1);
        check("coinc_flushed",    s_valid, 1'b0);
        check("coinc_adr",        s_adr,   32'hFFFF_FFFC);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1);
        check("coinc_wrap_adr",   s_adr,   32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1);
        check("coinc_wrap_pc",    s_pc,    32'hFFFF_FFFC);
        check("coinc_wrap_npc",   s_npc,   32'h0);

        // asynchronous reset mid-stream with three entries queued
        apply_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 32'h0, 1);
        check("mid_pre_valid", s_valid, 1'b1);
        apply_reset();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1);
        check("mid_restart_adr", s_adr, 32'h0);
        check("mid_restart_req", s_req, 1'b1);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b0, 32'h0, 1);

        // randomized traffic against the reference model
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            g  = ($urandom_range(0, 9) < 7);
            r  = ($urandom_range(0, 9) < 6);
            rd = ($urandom_range(0, 39) == 0);
            rp = $urandom() & 32'hFFFF_FFFC;
            drive(g, r, rd, rp, $urandom_range(1, 4));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/m_fetch_queue.md
# m_fetch_queue

Instruction-fetch front end for the two-stage RISC-V core. It sits directly upstream of the ID stage and replaces the single fetch register with a fetch-PC generator, a request/grant port to instruction memory, and a DEPTH-entry in-order instruction queue. Memory may have variable latency. The queue delivers `{ir, pc, npc}` to ID under a valid/ready handshake. A redirect from a taken branch flushes the queue and discards any fetches still in flight.

## Interface
- `DEPTH`, 4: queue entries; must be a power of 2 and ≥2. Also bounds outstanding plus queued fetches.
- `RESET_PC`, 32'h0: first fetch address after reset.

- `w_clk`  in  1  clock; all state updates on posedge.
- `w_rst_n`  in  1  reset; asynchronous, active-low.
- `w_redir`  in  1  branch-miss redirect from ID/EX.
- `w_redir_pc`  in  32  redirect target (`P1_pc + imm`).
- `w_imem_req`  out  1  fetch request valid.
- `w_imem_adr`  out  32  fetch address; word-aligned.
- `w_imem_gnt`  in  1  request accepted this cycle.
- `w_imem_rvalid`  in  1  response valid; responses return in request order.
- `w_imem_rdata`  in  32  instruction word.
- `w_id_valid`  out  1  queue head valid.
- `w_id_ir`  out  32  head instruction; 32'h13 (NOP) when empty.
- `w_id_pc`  out  32  head PC.
- `w_id_npc`  out  32  head PC + 4.
- `w_id_ready`  in  1  ID consumes the head.

## Operation
**Fetch PC**
- `r_fpc` drives `w_imem_adr`.
- On `req & gnt`, `r_fpc` increments by 4 (mod 2^32).
- On `w_redir`, `r_fpc` loads `w_redir_pc`.

**Credit count**
- `r_out` counts accepted-but-unreturned requests, range 0..DEPTH.
- `r_cnt` is queue occupancy.
- `w_imem_req = !w_redir & (r_out + r_cnt < DEPTH)`.

**Response PC**
- `r_rpc` is the PC of the next kept response.
- It loads `w_redir_pc` on redirect and increments by 4 for each kept response.

**Drop counter**
- `r_drop` counts responses to discard.
- On redirect: `r_drop <= r_out - w_imem_rvalid`.
- While `r_drop != 0`, each `rvalid` decrements `r_drop` and nothing is written to the queue.

**Enqueue**
- Condition: `rvalid & r_drop==0 & !w_redir`.
- Writes `{rdata, r_rpc}` at the tail.

**Dequeue**
- Condition: `w_id_valid & w_id_ready & !w_redir`.
- `w_id_valid = (r_cnt != 0)`.

**Redirect**
- Takes priority over everything else.
- Same cycle: queue flushed (`r_cnt <= 0`), no enqueue, no dequeue, request suppressed.

**Simultaneous enqueue and dequeue**
- Both occur; `r_cnt` is unchanged.
- Full queue plus dequeue is legal only because of credits; the credit rule prevents any overflow.

**Counter updates**
- `r_out` increments on `req & gnt` and decrements on every `rvalid` (kept or dropped).
- A response with `r_out == 0` is a protocol error: assertion fires and the response is ignored.

## Timing
**Reset values** (asserted asynchronously, take effect immediately):
- `r_fpc` = `RESET_PC`; `r_rpc` = `RESET_PC`.
- `r_out`, `r_cnt`, `r_drop` = 0.
- `w_imem_req` = 0 while `w_rst_n` = 0.
- `w_id_valid` = 0, `w_id_ir` = 32'h13, `w_id_pc` = 0, `w_id_npc` = 4.

**Start-up and latency**
- First request is asserted in the first cycle after reset deassertion.
- Queue write to `w_id_valid`: 1 cycle.
- Zero-wait memory (`gnt`=1, `rvalid` one cycle after grant): request at t, data at t+1, `w_id_valid` at t+2, then one instruction per cycle sustained.
- Redirect at t: request to `w_redir_pc` issued at t+1; first valid head no earlier than t+3.

**Output stability**
- `w_imem_adr` is stable while `req & !gnt`.
- The head is stable while `valid & !ready` and no redirect.

## Structure
- Shared package `fetch_pkg`:
  - `NOP_INSN` = 32'h13
  - `XLEN` = 32
  - `ILEN` = 32
  - default `RESET_PC`
- Sub-module `m_sync_fifo`:
  - parameterized width (64: ir + pc) and DEPTH.
  - ports: push, pop, flush, full, empty, count.
  - circular read/write pointers with log2(DEPTH)+1 bits for full/empty distinction.
- All credit, drop and PC logic lives in `m_fetch_queue`.

## Test plan
- **Streaming:** Reset, memory preloaded with word i = i·0x100+0x13, `gnt`=1, `rvalid` 1 cycle later, `ready`=1 → `w_id_pc` = 0,4,8,… one per cycle from cycle 2 after reset; `w_id_ir` matches memory.
- **Backpressure:** `ready`=0, DEPTH=4 → `r_cnt` saturates at 4, `w_imem_req` = 0 once `r_out+r_cnt` = 4; `ready`=1 → PCs 0,4,8,12,16 delivered in order, no loss or duplicate.
- **Redirect with fetches in flight:** memory latency 3, two requests outstanding, redirect to 0x100 → next two responses dropped, first `w_id_pc` = 0x100, `w_id_npc` = 0x104.
- **Grant stall:** `gnt`=0 for 3 cycles → `w_imem_adr` holds 0x8 for all 3 cycles, then advances to 0xC after the grant.
- **Coincident events:** Redirect in the same cycle as `rvalid` and `valid & ready` → response dropped, head not consumed, queue empty, `w_id_valid` = 0 next cycle.
- **Reset mid-stream:** Async reset asserted mid-stream with 3 entries queued → outputs take reset values without a clock edge; after release fetch restarts at `RESET_PC` and stale responses are never enqueued (bench holds `rvalid` low during reset).
